// File: rtl/btn_pkg.sv
// Shared debounce constants and width helpers.
// Used by the debouncer and the stopwatch top so that both derive the same sample tick.
package btn_pkg;

    localparam int DEF_CLK_HZ     = 100_000_000;
    localparam int DEF_TICK_HZ    = 1_000;
    localparam int DEF_STABLE_CNT = 8;
    localparam int DEF_LONG_CNT   = 1_000;

    // Clocks per sample tick, never below 1 even for odd parameter choices.
    function automatic int calcTickDiv(input int clkHz, input int tickHz);
        int div;
        div = (tickHz > 0) ? clkHz / tickHz : 1;
        return (div < 1) ? 1 : div;
    endfunction

    // Bits needed to hold values 0..maxVal.
    function automatic int cntWidth(input int maxVal);
        int w;
        w = $clog2(maxVal + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEF_TICK_DIV = calcTickDiv(DEF_CLK_HZ, DEF_TICK_HZ);

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: stable-sample counter, debounced level, edge pulses and long-press detect.
// Expects an already synchronized sample and a one-clock sample tick from the parent.
module debounce_ch
    import btn_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int LONG_CNT   = DEF_LONG_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_sample,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);

    localparam int STABLE_W = cntWidth(STABLE_CNT - 1);
    localparam int LONG_W   = cntWidth(LONG_CNT);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CNT - 1);
    localparam logic [LONG_W-1:0]   LONG_MAX    = LONG_W'(LONG_CNT);
    localparam logic [LONG_W-1:0]   LONG_LAST   = LONG_W'(LONG_CNT - 1);

    logic [STABLE_W-1:0] r_stable;
    logic [LONG_W-1:0]   r_long;
    logic                r_level;
    logic                r_rise;
    logic                r_fall;
    logic                r_longPulse;

    logic w_differ;
    logic w_accept;
    logic w_longHit;

    // A release landing on the same tick as the long threshold counts as a release only.
    always_comb begin
        w_differ  = i_sample ^ r_level;
        w_accept  = i_tick & w_differ & (r_stable == STABLE_LAST);
        w_longHit = i_tick & r_level & ~w_accept & (r_long == LONG_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stable    <= '0;
            r_long      <= '0;
            r_level     <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_longPulse <= 1'b0;
        end else begin
            r_rise      <= w_accept & ~r_level;
            r_fall      <= w_accept &  r_level;
            r_longPulse <= w_longHit;

            if (i_tick) begin
                if (!w_differ || w_accept) begin
                    r_stable <= '0;
                end else begin
                    r_stable <= r_stable + 1'b1;
                end
            end

            if (w_accept) begin
                r_level <= ~r_level;
            end

            if (!r_level || w_accept) begin
                r_long <= '0;
            end else if (i_tick && (r_long != LONG_MAX)) begin
                r_long <= r_long + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_long  = r_longPulse;

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel button debouncer: input synchronizers and a shared sample-tick prescaler
// feeding one debounce_ch per channel.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int TICK_HZ    = DEF_TICK_HZ,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int LONG_CNT   = DEF_LONG_CNT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_long,
    output logic            o_tick
);

    localparam int TICK_DIV = calcTickDiv(CLK_HZ, TICK_HZ);
    localparam int TICK_W   = cntWidth(TICK_DIV - 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'((TICK_DIV >= 2) ? TICK_DIV - 2 : 0);

    logic [N_CH-1:0]   r_sync1;
    logic [N_CH-1:0]   r_sync2;
    logic [TICK_W-1:0] r_tickCnt;
    logic              r_tick;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // The strobe is registered one count early so it is high exactly while the count sits at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tickCnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            if (r_tickCnt == TICK_LAST) begin
                r_tickCnt <= '0;
            end else begin
                r_tickCnt <= r_tickCnt + 1'b1;
            end
            r_tick <= (TICK_DIV == 1) ? 1'b1 : (r_tickCnt == TICK_PRE);
        end
    end

    assign o_tick = r_tick;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .STABLE_CNT (STABLE_CNT),
            .LONG_CNT   (LONG_CNT)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_tick   (r_tick),
            .i_sample (r_sync2[g]),
            .o_level  (o_level[g]),
            .o_rise   (o_rise[g]),
            .o_fall   (o_fall[g]),
            .o_long   (o_long[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi at TICK_DIV=10, STABLE_CNT=4, LONG_CNT=20, two channels.
// Table-driven press/glitch/release steps plus hand sequences for reset, latency and long-press timing.
module tb_btn_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] lng;
    logic       tick;

    int checksTotal  = 0;
    int checksPassed = 0;

    int cycleNum  = 0;
    int riseTot[2] = '{0, 0};
    int fallTot[2] = '{0, 0};
    int longTot[2] = '{0, 0};
    int bothTot   = 0;
    int lastRise1 = 0;
    int lastLong1 = 0;

    typedef struct {
        string      name;
        logic [1:0] btn;
        int         hold;
        logic [1:0] expLevel;
        int         expRise0;
        int         expRise1;
        int         expFall0;
        int         expFall1;
        int         expLong0;
        int         expLong1;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .N_CH       (2),
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .STABLE_CNT (4),
        .LONG_CNT   (20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn),
        .o_level (level),
        .o_rise  (rise),
        .o_fall  (fall),
        .o_long  (lng),
        .o_tick  (tick)
    );

    // Pulse accounting on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cycleNum++;
        for (int i = 0; i < 2; i++) begin
            if (rise[i]) riseTot[i]++;
            if (fall[i]) fallTot[i]++;
            if (lng[i])  longTot[i]++;
        end
        if (rise[1]) lastRise1 = cycleNum;
        if (lng[1])  lastLong1 = cycleNum;
        if ((rise & fall) != 2'b00) bothTot++;
    end

    task automatic tickClk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rstIn, input logic [1:0] btnIn, input int n);
        rst = rstIn;
        btn = btnIn;
        tickClk(n);
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checksTotal++;
        if (act == exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic waitRise(input int limit, output int lat);
        lat = -1;
        for (int n = 1; n <= limit; n++) begin
            tickClk(1);
            if (rise != 2'b00) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int per;
        int tk;
        int m;
        logic [1:0] capVal;
        int snapRise[2];
        int snapFall[2];
        int snapLong[2];

        vecs[0] = '{"release",    2'b00,  60, 2'b00, 0, 0, 1, 1, 0, 0};
        vecs[1] = '{"glitchHigh", 2'b01,  25, 2'b00, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{"glitchLow",  2'b00,  60, 2'b00, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{"press0",     2'b01, 100, 2'b01, 1, 0, 0, 0, 0, 0};
        vecs[4] = '{"release0",   2'b00,  60, 2'b00, 0, 0, 1, 0, 0, 0};
        vecs[5] = '{"longPress1", 2'b10, 400, 2'b10, 0, 1, 0, 0, 0, 1};
        vecs[6] = '{"release1",   2'b00,  60, 2'b00, 0, 0, 0, 1, 0, 0};

        // Reset held with both buttons high.
        applyStimulus(1'b0, 2'b11, 3);
        checkOutput("reset.level", int'(level), 0);
        checkOutput("reset.rise",  int'(rise),  0);
        checkOutput("reset.fall",  int'(fall),  0);
        checkOutput("reset.long",  int'(lng),   0);
        checkOutput("reset.tick",  int'(tick),  0);

        rst = 1'b1;
        waitRise(42, lat);
        capVal = rise;
        checkOutput("rstRelease.latency", lat, 40);
        checkOutput("rstRelease.rise",    int'(capVal), 3);
        checkOutput("rstRelease.level",   int'(level),  3);

        // Tick period.
        per = -1;
        for (int n = 1; n <= 20; n++) begin
            tickClk(1);
            if (tick) break;
        end
        for (int n = 1; n <= 20; n++) begin
            tickClk(1);
            if (tick) begin
                per = n;
                break;
            end
        end
        checkOutput("tick.period", per, 10);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 2; i++) begin
                snapRise[i] = riseTot[i];
                snapFall[i] = fallTot[i];
                snapLong[i] = longTot[i];
            end
            applyStimulus(1'b1, vecs[v].btn, vecs[v].hold);
            checkOutput({vecs[v].name, ".level"}, int'(level), int'(vecs[v].expLevel));
            checkOutput({vecs[v].name, ".rise0"}, riseTot[0] - snapRise[0], vecs[v].expRise0);
            checkOutput({vecs[v].name, ".rise1"}, riseTot[1] - snapRise[1], vecs[v].expRise1);
            checkOutput({vecs[v].name, ".fall0"}, fallTot[0] - snapFall[0], vecs[v].expFall0);
            checkOutput({vecs[v].name, ".fall1"}, fallTot[1] - snapFall[1], vecs[v].expFall1);
            checkOutput({vecs[v].name, ".long0"}, longTot[0] - snapLong[0], vecs[v].expLong0);
            checkOutput({vecs[v].name, ".long1"}, longTot[1] - snapLong[1], vecs[v].expLong1);
        end
        checkOutput("longPress1.delay", lastLong1 - lastRise1, 200);

        // Simultaneous press on both channels.
        applyStimulus(1'b1, 2'b11, 0);
        waitRise(45, lat);
        capVal = rise;
        checkOutput("simul.rise", int'(capVal), 3);

        // Reset in the middle of the long count.
        tk = 0;
        for (int n = 1; n <= 150; n++) begin
            tickClk(1);
            if (tick) tk++;
            if (tk == 10) break;
        end
        checkOutput("midReset.ticks", tk, 10);
        snapLong[0] = longTot[0];
        snapLong[1] = longTot[1];
        applyStimulus(1'b0, 2'b11, 2);
        checkOutput("midReset.level", int'(level), 0);

        rst = 1'b1;
        waitRise(42, lat);
        capVal = rise;
        checkOutput("midReset.latency", lat, 40);
        checkOutput("midReset.rise",    int'(capVal), 3);
        checkOutput("midReset.noLong0", longTot[0] - snapLong[0], 0);
        checkOutput("midReset.noLong1", longTot[1] - snapLong[1], 0);

        m = -1;
        capVal = 2'b00;
        for (int n = 1; n <= 230; n++) begin
            tickClk(1);
            if (lng != 2'b00) begin
                m = n;
                capVal = lng;
                break;
            end
        end
        checkOutput("restart.longDelay", m, 200);
        checkOutput("restart.long",      int'(capVal), 3);

        applyStimulus(1'b1, 2'b00, 60);
        checkOutput("final.level", int'(level), 0);
        checkOutput("riseFallExclusive", bothTot, 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
